// File: rtl/adc_acq_selftrig_seq.sv
// adc_acq_selftrig_seq: turns a fill window and self-trigger pulses into mux strobes, header fields and DDR3 write strobes
module adc_acq_selftrig_seq #(
    parameter logic [22:0] MAX_BURSTS = 23'd8388607
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        acq_start_i,
    input  logic        acq_stop_i,
    input  logic        trig_i,
    input  logic [13:0] async_num_bursts_i,
    output logic        select_fill_hdr_o,
    output logic        select_waveform_hdr_o,
    output logic        select_dat_o,
    output logic        select_checksum_o,
    output logic        checksum_init_o,
    output logic        checksum_update_o,
    output logic [22:0] current_waveform_num_o,
    output logic [22:0] waveform_start_adr_o,
    output logic [22:0] num_fill_bursts_o,
    output logic [41:0] trigger_time_o,
    output logic        ddr3_wr_en_o,
    output logic [22:0] ddr3_wr_adr_o,
    output logic        busy_o,
    output logic        fill_done_o,
    output logic [15:0] dropped_trigs_o
);
    typedef enum logic [2:0] {IDLE, ARMED, WFM_HDR, WFM_DAT, FILL_HDR, CHKSUM} state_t;

    state_t      state_q;
    logic        sel_fill_q, sel_whdr_q, sel_dat_q, sel_chk_q, init_q, busy_q, done_q, stop_q;
    logic        wr_en_q;
    logic [22:0] bcnt_q, wfm_q, wsa_q, nfb_q, wr_adr_q;
    logic [13:0] n_q, rem_q;
    logic [41:0] tcnt_q, tt_q;
    logic [15:0] drop_q;
    logic        fits, drop, last, stop_any;

    // the waveform plus the fill header and checksum words must still fit in the buffer
    assign fits = ({2'b0, bcnt_q} + {11'b0, async_num_bursts_i} + 25'd3) <= {2'b0, MAX_BURSTS};
    assign drop = trig_i && ((state_q == ARMED && (acq_stop_i || !fits)) || state_q == WFM_HDR || state_q == WFM_DAT);
    assign last = (state_q == WFM_HDR) ? (n_q == 14'd0) : (rem_q == 14'd1);
    assign stop_any = stop_q || acq_stop_i;

    // sequencer: state, registered selects, header fields and the one-cycle-delayed write strobe
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            sel_fill_q <= 1'b0;
            sel_whdr_q <= 1'b0;
            sel_dat_q  <= 1'b0;
            sel_chk_q  <= 1'b0;
            init_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            stop_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            bcnt_q     <= '0;
            wfm_q      <= '0;
            wsa_q      <= '0;
            nfb_q      <= '0;
            wr_adr_q   <= '0;
            n_q        <= '0;
            rem_q      <= '0;
            tcnt_q     <= '0;
            tt_q       <= '0;
            drop_q     <= '0;
        end else begin
            sel_fill_q <= 1'b0;
            sel_whdr_q <= 1'b0;
            sel_dat_q  <= 1'b0;
            sel_chk_q  <= 1'b0;
            init_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_en_q    <= sel_fill_q || sel_whdr_q || sel_dat_q || sel_chk_q;
            wr_adr_q   <= sel_fill_q ? 23'd0 : bcnt_q;
            if (state_q == ARMED || state_q == WFM_HDR || state_q == WFM_DAT)
                tcnt_q <= tcnt_q + 42'd1;
            if (drop && !(&drop_q))
                drop_q <= drop_q + 16'd1;
            case (state_q)
                IDLE: if (acq_start_i) begin
                    state_q <= ARMED;
                    init_q  <= 1'b1;
                    busy_q  <= 1'b1;
                    stop_q  <= 1'b0;
                    tcnt_q  <= '0;
                    bcnt_q  <= 23'd1;
                    wfm_q   <= '0;
                    wsa_q   <= '0;
                    nfb_q   <= '0;
                    tt_q    <= '0;
                    drop_q  <= '0;
                end
                ARMED: if (acq_stop_i) begin
                    state_q    <= FILL_HDR;
                    sel_fill_q <= 1'b1;
                    nfb_q      <= bcnt_q + 23'd1;
                end else if (trig_i && fits) begin
                    state_q    <= WFM_HDR;
                    sel_whdr_q <= 1'b1;
                    tt_q       <= tcnt_q;
                    wsa_q      <= bcnt_q;
                    n_q        <= async_num_bursts_i;
                end
                WFM_HDR, WFM_DAT: begin
                    bcnt_q <= bcnt_q + 23'd1;
                    rem_q  <= (state_q == WFM_HDR) ? n_q : rem_q - 14'd1;
                    stop_q <= stop_any;
                    if (state_q == WFM_HDR)
                        wfm_q <= wfm_q + 23'd1;
                    if (last) begin
                        state_q    <= stop_any ? FILL_HDR : ARMED;
                        sel_fill_q <= stop_any;
                        nfb_q      <= bcnt_q + 23'd2;
                    end else begin
                        state_q   <= WFM_DAT;
                        sel_dat_q <= 1'b1;
                    end
                end
                FILL_HDR: begin
                    state_q   <= CHKSUM;
                    sel_chk_q <= 1'b1;
                end
                CHKSUM: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign select_fill_hdr_o      = sel_fill_q;
    assign select_waveform_hdr_o  = sel_whdr_q;
    assign select_dat_o           = sel_dat_q;
    assign select_checksum_o      = sel_chk_q;
    assign checksum_init_o        = init_q;
    assign checksum_update_o      = sel_dat_q;
    assign current_waveform_num_o = wfm_q;
    assign waveform_start_adr_o   = wsa_q;
    assign num_fill_bursts_o      = nfb_q;
    assign trigger_time_o         = tt_q;
    assign ddr3_wr_en_o           = wr_en_q;
    assign ddr3_wr_adr_o          = wr_adr_q;
    assign busy_o                 = busy_q;
    assign fill_done_o            = done_q;
    assign dropped_trigs_o        = drop_q;
endmodule
